// File: rtl/alien_formation_ctrl.sv
// Runtime owner of the 12-alien formation: alive mask, horizontal sway,
// hit handling and the clear/pause/respawn wave sequence.
module alien_formation_ctrl #(
  parameter int NUM_ALIENS   = 12,
  parameter int STEP         = 1,
  parameter int MAX_OFF      = 100,
  parameter int FRAME_DIV    = 2,
  parameter int CLEAR_FRAMES = 60
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_tick,
  input  logic                    start,
  input  logic                    hit_valid,
  input  logic [3:0]              hit_idx,
  output logic [NUM_ALIENS-1:0]   alive,
  output logic [7:0]              offset_x,
  output logic [10*NUM_ALIENS-1:0] alien_x,
  output logic [10*NUM_ALIENS-1:0] alien_y,
  output logic [7:0]              wave,
  output logic                    wave_clear,
  output logic                    busy
);

  typedef enum logic [1:0] {S_IDLE, S_MARCH, S_CLEAR} state_t;

  localparam int DW = $clog2(FRAME_DIV) + 1;
  localparam int CW = $clog2(CLEAR_FRAMES) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_FRAMES - 1);
  localparam logic signed [9:0] STEP_S = 10'(STEP);
  localparam logic signed [9:0] MAX_S  = 10'(MAX_OFF);
  localparam logic [9:0] BASE_X [12] = '{10'd200, 10'd250, 10'd300, 10'd350, 10'd400,
                                         10'd150, 10'd200, 10'd250, 10'd300, 10'd350,
                                         10'd400, 10'd450};

  state_t                state, state_n;
  logic [NUM_ALIENS-1:0] alive_n;
  logic [7:0]            offset_n, wave_n;
  logic                  dir, dir_n;          // 0 = moving right, 1 = moving left
  logic [DW-1:0]         div_cnt, div_cnt_n;
  logic [CW-1:0]         clr_cnt, clr_cnt_n;
  logic                  wave_clear_n;
  logic signed [9:0]     off_ext;

  assign off_ext = {{2{offset_x[7]}}, offset_x};
  assign busy    = (state != S_IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      alive      <= '0;
      offset_x   <= '0;
      dir        <= 1'b0;
      div_cnt    <= '0;
      clr_cnt    <= '0;
      wave       <= '0;
      wave_clear <= 1'b0;
    end else begin
      state      <= state_n;
      alive      <= alive_n;
      offset_x   <= offset_n;
      dir        <= dir_n;
      div_cnt    <= div_cnt_n;
      clr_cnt    <= clr_cnt_n;
      wave       <= wave_n;
      wave_clear <= wave_clear_n;
    end
  end

  always_comb begin
    state_n      = state;
    alive_n      = alive;
    offset_n     = offset_x;
    dir_n        = dir;
    div_cnt_n    = div_cnt;
    clr_cnt_n    = clr_cnt;
    wave_n       = wave;
    wave_clear_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n   = S_MARCH;
          alive_n   = '1;
          offset_n  = '0;
          dir_n     = 1'b0;
          div_cnt_n = '0;
          wave_n    = 8'd1;
        end
      end
      S_MARCH: begin
        if (alive == '0) begin
          state_n      = S_CLEAR;
          wave_clear_n = 1'b1;
        end
        if (frame_tick) begin
          if (div_cnt == DIV_LAST) begin
            div_cnt_n = '0;
            // Reversal happens on the move that would overshoot, stepping back at once.
            if (!dir) begin
              if (off_ext + STEP_S > MAX_S) begin
                dir_n    = 1'b1;
                offset_n = 8'(off_ext - STEP_S);
              end else begin
                offset_n = 8'(off_ext + STEP_S);
              end
            end else begin
              if (off_ext - STEP_S < -MAX_S) begin
                dir_n    = 1'b0;
                offset_n = 8'(off_ext + STEP_S);
              end else begin
                offset_n = 8'(off_ext - STEP_S);
              end
            end
          end else begin
            div_cnt_n = div_cnt + DW'(1);
          end
        end
        if (hit_valid && (hit_idx < 4'(NUM_ALIENS)))
          alive_n[hit_idx] = 1'b0;
      end
      S_CLEAR: begin
        if (frame_tick) begin
          if (clr_cnt == CLR_LAST) begin
            state_n   = S_MARCH;
            alive_n   = '1;
            offset_n  = '0;
            dir_n     = 1'b0;
            div_cnt_n = '0;
            clr_cnt_n = '0;
            wave_n    = (wave == 8'hFF) ? wave : wave + 8'd1;
          end else begin
            clr_cnt_n = clr_cnt + CW'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_ALIENS; g++) begin : g_pos
    assign alien_x[10*g +: 10] = BASE_X[g] + off_ext;
    assign alien_y[10*g +: 10] = (g < 5) ? 10'd50 : 10'd100;
  end

endmodule

// File: tb/tb_alien_formation_ctrl.sv
// Randomized bench for alien_formation_ctrl against a frame-count based reference model.
module tb_alien_formation_ctrl;
  localparam int FD = 2;
  localparam int CF = 60;
  localparam int MX = 100;
  localparam int BX[12] = '{200, 250, 300, 350, 400, 150, 200, 250, 300, 350, 400, 450};

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         frame_tick = 1'b0;
  logic         start = 1'b0;
  logic         hit_valid = 1'b0;
  logic [3:0]   hit_idx = '0;
  logic [11:0]  alive;
  logic [7:0]   offset_x;
  logic [119:0] alien_x;
  logic [119:0] alien_y;
  logic [7:0]   wave;
  logic         wave_clear;
  logic         busy;

  alien_formation_ctrl #(
    .NUM_ALIENS(12), .STEP(1), .MAX_OFF(MX), .FRAME_DIV(FD), .CLEAR_FRAMES(CF)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .alive(alive), .offset_x(offset_x),
    .alien_x(alien_x), .alien_y(alien_y), .wave(wave), .wave_clear(wave_clear), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 marching, 2 cleared; offset derived from tick count.
  int          m_phase = 0;
  logic [11:0] m_alive = '0;
  int          m_ticks = 0;
  int          m_clr = 0;
  int          m_wave = 0;
  int          m_wclear = 0;

  function automatic int tri_off(input int moves);
    int p;
    p = moves % (4 * MX);
    if (p <= MX) return p;
    else if (p <= 3 * MX) return 2 * MX - p;
    else return p - 4 * MX;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_phase = 0; m_alive = '0; m_ticks = 0; m_clr = 0; m_wave = 0; m_wclear = 0;
    end else begin
      m_wclear = 0;
      case (m_phase)
        0: if (start) begin
             m_phase = 1; m_alive = 12'hFFF; m_ticks = 0; m_wave = 1;
           end
        1: begin
             if (m_alive == 12'h000) begin
               m_phase = 2; m_wclear = 1; m_clr = 0;
             end
             if (frame_tick) m_ticks++;
             if (hit_valid && hit_idx < 12) m_alive[hit_idx] = 1'b0;
           end
        default: if (frame_tick) begin
             m_clr++;
             if (m_clr == CF) begin
               m_clr = 0; m_phase = 1; m_alive = 12'hFFF; m_ticks = 0;
               if (m_wave < 255) m_wave++;
             end
           end
      endcase
    end
  end

  int cj, coff;
  always @(negedge Clk) begin
    if (Reset_n) begin
      coff = tri_off(m_ticks / FD);
      cj = $urandom_range(11);
      check_eq("alive", int'(alive), int'(m_alive));
      check_eq("offset_x", int'($signed(offset_x)), coff);
      check_eq("wave", int'(wave), m_wave);
      check_eq("wave_clear", int'(wave_clear), m_wclear);
      check_eq("busy", int'(busy), int'(m_phase != 0));
      check_eq("alien_x", int'(alien_x[10*cj +: 10]), (BX[cj] + coff) & 1023);
      check_eq("alien_y", int'(alien_y[10*cj +: 10]), (cj < 5) ? 50 : 100);
      check_eq("off_range", int'(coff >= -MX && coff <= MX &&
               $signed(offset_x) >= -MX && $signed(offset_x) <= MX), 1);
    end
  end

  task automatic drive(input bit ft, input bit st, input bit hv, input int hi);
    @(negedge Clk);
    frame_tick = ft; start = st; hit_valid = hv; hit_idx = 4'(hi);
  endtask

  task automatic do_start();
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
  endtask

  int budget, wc_cnt, target;

  initial begin
    repeat (3) @(negedge Clk);
    check_eq("rst_alive", int'(alive), 0);
    check_eq("rst_offset", int'(offset_x), 0);
    check_eq("rst_wave", int'(wave), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_wclear", int'(wave_clear), 0);
    Reset_n = 1'b1;

    // start has no effect until seen; frame ticks in idle ignored
    drive(1, 0, 1, 2);
    do_start();
    check_eq("start_alive", int'(alive), 12'hFFF);
    check_eq("start_wave", int'(wave), 1);
    check_eq("start_off", int'(offset_x), 0);
    check_eq("start_x0", int'(alien_x[9:0]), 200);
    check_eq("start_x11", int'(alien_x[119:110]), 450);
    check_eq("start_y5", int'(alien_y[59:50]), 100);
    check_eq("start_busy", int'(busy), 1);

    drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(0, 0, 0, 0);
    check_eq("step_off", int'($signed(offset_x)), 1);
    check_eq("step_x0", int'(alien_x[9:0]), 201);
    check_eq("step_x5", int'(alien_x[59:50]), 151);

    // full sway cycle with random tick spacing, start pulses ignored
    budget = 6000;
    while (m_ticks < 1300 && budget > 0) begin
      drive(($urandom_range(1) == 1), ($urandom_range(7) == 0), 0, 0);
      budget--;
    end
    check_eq("sway_timeout", int'(budget > 0), 1);

    drive(0, 0, 1, 3); drive(0, 0, 1, 3); drive(0, 0, 1, 13);
    drive(1, 0, 1, 7); drive(0, 0, 0, 0);
    check_eq("hits_alive", int'(alive), 12'hF77);

    for (int i = 0; i < 12; i++) drive(($urandom_range(1) == 1), 0, 1, i);
    wc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      wc_cnt += int'(wave_clear);
      frame_tick = ($urandom_range(1) == 1); hit_valid = 1'b1; hit_idx = 4'($urandom_range(11));
    end
    check_eq("wc_pulses", wc_cnt, 1);

    budget = 1000;
    while (m_wave != 2 && budget > 0) begin
      drive(($urandom_range(1) == 1), 0, ($urandom_range(1) == 1), $urandom_range(15));
      budget--;
    end
    check_eq("clear_timeout", int'(budget > 0), 1);
    check_eq("resp_alive", int'(alive), 12'hFFF);
    check_eq("resp_off", int'(offset_x), 0);
    check_eq("resp_wave", int'(wave), 2);

    // random waves with mixed hits and ticks
    for (int w = 0; w < 3; w++) begin
      target = m_wave + 1;
      budget = 4000;
      while (m_wave != target && budget > 0) begin
        drive(($urandom_range(2) == 0), ($urandom_range(9) == 0),
              ($urandom_range(3) == 0), $urandom_range(15));
        budget--;
      end
      check_eq("wave_timeout", int'(budget > 0), 1);
    end

    // asynchronous reset mid-march
    @(negedge Clk); Reset_n = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;
    do_start();
    for (int i = 0; i < 12; i++) if (i < 4 || i > 7) drive(0, 0, 1, i);
    repeat (74) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    check_eq("pre_rst_off", int'($signed(offset_x)), 37);
    check_eq("pre_rst_alive", int'(alive), 12'h0F0);
    #2 Reset_n = 1'b0;
    #1;
    check_eq("arst_alive", int'(alive), 0);
    check_eq("arst_off", int'(offset_x), 0);
    check_eq("arst_wave", int'(wave), 0);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_x0", int'(alien_x[9:0]), 200);
    @(negedge Clk); Reset_n = 1'b1;
    do_start();
    check_eq("restart_wave", int'(wave), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
